// File: rtl/pacman_pkg.sv
// Shared types and sizing for the pacman game-control blocks.
package pacman_pkg;

    typedef enum logic [1:0] {PLAY, DEATH, GAMEOVER, WIN} life_state_t;

    localparam int NUM_GHOSTS = 4;

endpackage

// File: rtl/hit_detect.sv
// Box-overlap test between pacman and one ghost; touching edges do not count.
module hit_detect (
    input  logic [9:0] pX,
    input  logic [9:0] pY,
    input  logic [9:0] pS,
    input  logic [9:0] gX,
    input  logic [9:0] gY,
    input  logic [9:0] gS,
    output logic       hit
);

    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [10:0] sum;

    always_comb begin
        dx = (pX >= gX) ? (pX - gX) : (gX - pX);
        dy = (pY >= gY) ? (pY - gY) : (gY - pY);
    end

    // Widen before adding so two large half-sizes cannot wrap.
    assign sum = {1'b0, pS} + {1'b0, gS};
    assign hit = ({1'b0, dx} < sum) && ({1'b0, dy} < sum);

endmodule

// File: rtl/life_manager.sv
// Collision, lives and death-freeze sequencing; also handles win and restart.
module life_manager
    import pacman_pkg::*;
#(
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned DEATH_FRAMES = 60,
    parameter logic [7:0]  RESTART_KEY  = 8'h28
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        frame_clk,
    input  logic [9:0]                  pX,
    input  logic [9:0]                  pY,
    input  logic [9:0]                  pS,
    input  logic [0:NUM_GHOSTS-1][9:0]  gX,
    input  logic [0:NUM_GHOSTS-1][9:0]  gY,
    input  logic [0:NUM_GHOSTS-1][9:0]  gS,
    input  logic [31:0]                 dots_left,
    input  logic [7:0]                  keycode,
    output logic                        lifeDown,
    output logic                        restart,
    output logic [1:0]                  lives,
    output logic                        freeze,
    output logic                        game_over,
    output logic                        win
);

    life_state_t           state;
    logic [7:0]            death_cnt;
    logic                  frame_prev;
    logic                  tick;
    logic [NUM_GHOSTS-1:0] hit;
    logic                  any_hit;

    for (genvar i = 0; i < NUM_GHOSTS; i++) begin : g_hit
        hit_detect u_hit (
            .pX  (pX),
            .pY  (pY),
            .pS  (pS),
            .gX  (gX[i]),
            .gY  (gY[i]),
            .gS  (gS[i]),
            .hit (hit[i])
        );
    end

    assign any_hit = |hit;
    assign tick    = frame_clk & ~frame_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= PLAY;
            lives      <= 2'(START_LIVES);
            death_cnt  <= '0;
            frame_prev <= 1'b0;
            lifeDown   <= 1'b0;
            restart    <= 1'b0;
        end else begin
            frame_prev <= frame_clk;
            lifeDown   <= 1'b0;
            restart    <= 1'b0;
            case (state)
                PLAY: if (tick) begin
                    // An empty board wins even if a ghost is touching pacman.
                    if (dots_left == '0) begin
                        state <= WIN;
                    end else if (any_hit) begin
                        lifeDown <= 1'b1;
                        if (lives > 2'd1) begin
                            lives     <= lives - 2'd1;
                            death_cnt <= 8'(DEATH_FRAMES);
                            state     <= DEATH;
                        end else begin
                            lives <= 2'd0;
                            state <= GAMEOVER;
                        end
                    end
                end
                DEATH: if (tick) begin
                    if (death_cnt == 8'd1) state <= PLAY;
                    death_cnt <= death_cnt - 8'd1;
                end
                GAMEOVER, WIN: if (keycode == RESTART_KEY) begin
                    restart <= 1'b1;
                    lives   <= 2'(START_LIVES);
                    state   <= PLAY;
                end
                default: state <= PLAY;
            endcase
        end
    end

    assign freeze    = (state != PLAY);
    assign game_over = (state == GAMEOVER);
    assign win       = (state == WIN);

endmodule

// File: tb/tb_life_manager.sv
// Directed plus random stimulus against a frame-level model of the life rules.
module tb_life_manager;

    localparam int         START = 3;
    localparam int         DF    = 60;
    localparam logic [7:0] KEY   = 8'h28;

    localparam int M_PLAY = 0, M_DEATH = 1, M_OVER = 2, M_WIN = 3;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             frame_clk = 1'b0;
    logic [9:0]       pX, pY, pS;
    logic [0:3][9:0]  gX, gY, gS;
    logic [31:0]      dots_left;
    logic [7:0]       keycode;
    logic             lifeDown, restart, freeze, game_over, win;
    logic [1:0]       lives;

    life_manager dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .pX        (pX),
        .pY        (pY),
        .pS        (pS),
        .gX        (gX),
        .gY        (gY),
        .gS        (gS),
        .dots_left (dots_left),
        .keycode   (keycode),
        .lifeDown  (lifeDown),
        .restart   (restart),
        .lives     (lives),
        .freeze    (freeze),
        .game_over (game_over),
        .win       (win)
    );

    always #10 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Model: game mode, lives, and how many more frame ticks the freeze lasts.
    int m_mode = M_PLAY;
    int m_lives = START;
    int m_freeze_left = 0;
    bit m_fprev = 1'b0;
    bit m_ld = 1'b0;
    bit m_rs = 1'b0;

    function automatic bit overlaps(int g);
        int dx, dy, reach;
        dx = int'(pX) - int'(gX[g]);
        dy = int'(pY) - int'(gY[g]);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        reach = int'(pS) + int'(gS[g]);
        return (dx < reach) && (dy < reach);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit tick, touching;
        m_ld = 1'b0;
        m_rs = 1'b0;
        if (Reset) begin
            m_mode = M_PLAY;
            m_lives = START;
            m_freeze_left = 0;
            m_fprev = 1'b0;
            return;
        end
        tick = frame_clk && !m_fprev;
        m_fprev = frame_clk;
        touching = 1'b0;
        for (int g = 0; g < 4; g++) if (overlaps(g)) touching = 1'b1;
        case (m_mode)
            M_PLAY: if (tick) begin
                if (dots_left == 0) m_mode = M_WIN;
                else if (touching) begin
                    m_ld = 1'b1;
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_mode = M_OVER;
                    else begin
                        m_mode = M_DEATH;
                        m_freeze_left = DF;
                    end
                end
            end
            M_DEATH: if (tick) begin
                m_freeze_left = m_freeze_left - 1;
                if (m_freeze_left == 0) m_mode = M_PLAY;
            end
            default: if (keycode == KEY) begin
                m_rs = 1'b1;
                m_lives = START;
                m_mode = M_PLAY;
            end
        endcase
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clk);
        #1;
        chk("lifeDown", 32'(lifeDown), 32'(m_ld));
        chk("restart", 32'(restart), 32'(m_rs));
        chk("lives", 32'(lives), 32'(m_lives));
        chk("freeze", 32'(freeze), 32'(m_mode != M_PLAY));
        chk("game_over", 32'(game_over), 32'(m_mode == M_OVER));
        chk("win", 32'(win), 32'(m_mode == M_WIN));
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_clk = 1'b1;
            cycle();
            cycle();
            frame_clk = 1'b0;
            cycle();
            cycle();
        end
    endtask

    task automatic ghosts_away();
        for (int g = 0; g < 4; g++) begin
            gX[g] = 10'd300;
            gY[g] = 10'd300;
            gS[g] = 10'd6;
        end
    endtask

    initial begin
        pX = 10'd100; pY = 10'd100; pS = 10'd6;
        ghosts_away();
        dots_left = 32'd100;
        keycode = 8'h00;

        // Reset and idle play
        Reset = 1'b1;
        cycle();
        cycle();
        Reset = 1'b0;
        chk("reset_lives", 32'(lives), 32'd3);
        chk("reset_freeze", 32'(freeze), 32'd0);
        frames(3);
        chk("idle_lives", 32'(lives), 32'd3);

        // Ghost 0 hit, overlap kept through most of the freeze
        gX[0] = 10'd110; gY[0] = 10'd100;
        frames(1);
        chk("hit0_lives", 32'(lives), 32'd2);
        chk("hit0_freeze", 32'(freeze), 32'd1);
        frames(58);
        ghosts_away();
        frames(1);
        chk("death_59_freeze", 32'(freeze), 32'd1);
        frames(1);
        chk("death_end_freeze", 32'(freeze), 32'd0);
        chk("death_end_lives", 32'(lives), 32'd2);

        // Touching edge is not a hit; one pixel closer is
        gX[2] = 10'd112; gY[2] = 10'd100;
        frames(2);
        chk("edge_no_hit", 32'(lives), 32'd2);
        gX[2] = 10'd111;
        frames(1);
        chk("edge_hit", 32'(lives), 32'd1);
        ghosts_away();
        frames(60);

        // Last life lost, then restart on Enter
        gX[1] = 10'd100; gY[1] = 10'd94;
        frames(1);
        chk("last_life", 32'(lives), 32'd0);
        chk("game_over", 32'(game_over), 32'd1);
        ghosts_away();
        keycode = KEY;
        cycle();
        chk("restart_pulse", 32'(restart), 32'd1);
        chk("restart_lives", 32'(lives), 32'd3);
        frames(2);
        keycode = 8'h00;

        // Win beats a simultaneous hit; wrong key ignored
        dots_left = 32'd0;
        gX[3] = 10'd95; gY[3] = 10'd105;
        frames(1);
        chk("win_level", 32'(win), 32'd1);
        chk("win_lives", 32'(lives), 32'd3);
        keycode = 8'h1A;
        frames(2);
        chk("win_wrong_key", 32'(win), 32'd1);
        keycode = KEY;
        cycle();
        chk("win_restart", 32'(restart), 32'd1);
        keycode = 8'h00;
        dots_left = 32'd100;
        ghosts_away();
        cycle();

        // Reset in the middle of a death freeze
        gX[0] = 10'd100; gY[0] = 10'd100;
        frames(1);
        ghosts_away();
        frames(30);
        chk("mid_death_freeze", 32'(freeze), 32'd1);
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        chk("mid_reset_lives", 32'(lives), 32'd3);
        chk("mid_reset_freeze", 32'(freeze), 32'd0);
        cycle();

        // Random play
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 50) == 0) begin
                pX = 10'($urandom_range(0, 1023));
                pY = 10'($urandom_range(0, 1023));
                pS = 10'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 7) == 0) begin
                for (int g = 0; g < 4; g++) begin
                    gX[g] = 10'(int'(pX) + int'($urandom_range(0, 80)) - 40);
                    gY[g] = 10'(int'(pY) + int'($urandom_range(0, 80)) - 40);
                    gS[g] = 10'($urandom_range(0, 15));
                end
            end
            dots_left = ($urandom_range(0, 80) == 0) ? 32'd0 : 32'd500;
            keycode = ($urandom_range(0, 30) == 0) ? KEY : 8'($urandom_range(0, 255));
            Reset = ($urandom_range(0, 900) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
